pwm_from_cnt: RTL and testbench

Downstream consumer of the free-running 4-bit counter: samples the counter value each clock and turns it into a registered PWM output whose duty is programmed through a valid/ready load port. A new duty value is buffered and applied only at a counter wrap, so every PWM period is glitch-free. It also emits a one-cycle period pulse that downstream logic uses as a frame tick.

---
 rtl/pwm_from_cnt_pkg.sv | 18 +
 rtl/pwm_from_cnt_wrap_det.sv | 39 +++
 rtl/pwm_from_cnt.sv | 96 +++++++++
 tb/tb_pwm_from_cnt.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_from_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_from_cnt_pkg
// Purpose  : Shared sizing constants for the counter-driven PWM block and
//            other consumers of the free-running counter.
//            CNT_WIDTH - default width of the sampled counter value
//            DUTY_W    - width of a duty value (CNT_WIDTH+1, so full scale fits)
//            DUTY_MAX  - full-scale duty, 2^CNT_WIDTH counts
// Revision : 1.0 - initial release
// ============================================================================
package pwm_from_cnt_pkg;

    localparam int CNT_WIDTH = 4;
    localparam int DUTY_W    = CNT_WIDTH + 1;
    localparam int DUTY_MAX  = 1 << CNT_WIDTH;

endpackage : pwm_from_cnt_pkg
`default_nettype wire

// File: rtl/pwm_from_cnt_wrap_det.sv
`default_nettype none
// ============================================================================
// Module   : cnt_wrap_det
// Purpose  : Remembers the previous counter sample and flags a period start
//            whenever the counter reads zero after a nonzero value. This covers
//            the natural roll-over and a counter reset from any value, and a
//            counter parked at zero raises the flag only once.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-low reset
//            cnt      - counter value sampled this cycle
//            wrap_evt - combinational period-start flag for this cycle
// Revision : 1.0 - initial release
// ============================================================================
module cnt_wrap_det
    import pwm_from_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    output logic             wrap_evt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt;
        end
    end

    // cnt_q resets to zero, so the first zero sample after reset is not a wrap.
    assign wrap_evt = (cnt == '0) && (cnt_q != '0);

endmodule : cnt_wrap_det
`default_nettype wire

// File: rtl/pwm_from_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pwm_from_cnt
// Purpose  : Turns the sampled free-running counter into a registered PWM
//            output. Duty values arrive on a valid/ready port, are buffered in
//            a one-entry holding register and applied only at a counter wrap,
//            so every PWM period is glitch-free. Also emits a one-cycle wrap
//            pulse usable as a frame tick.
// Ports    : clk      - rising-edge clock (same as the counter)
//            rst      - asynchronous active-low reset
//            cnt      - counter value, sampled every clk
//            en       - output enable, gates pwm only
//            duty_in  - requested high time in counts (values above full
//                       scale are clamped to full scale)
//            duty_vld - duty_in is valid
//            duty_rdy - holding register empty, a duty value can be accepted
//            duty_cur - duty currently in force
//            pwm      - registered PWM output
//            wrap     - registered one-cycle period-start pulse
// Revision : 1.0 - initial release
// ============================================================================
module pwm_from_cnt
    import pwm_from_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_vld,
    output logic             duty_rdy,
    output logic [WIDTH:0]   duty_cur,
    output logic             pwm,
    output logic             wrap
);

    localparam int DW = WIDTH + 1;
    localparam logic [DW-1:0] DMAX = {1'b1, {WIDTH{1'b0}}};

    function automatic logic [DW-1:0] sat(input logic [DW-1:0] v);
        sat = (v > DMAX) ? DMAX : v;
    endfunction

    logic          wrap_evt;
    logic [DW-1:0] pend;
    logic          pend_vld;
    logic [DW-1:0] duty_act;
    logic [DW-1:0] duty_eff;
    logic          xfer;
    logic          apply;

    cnt_wrap_det #(
        .WIDTH    (WIDTH)
    ) u_wrap_det (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .wrap_evt (wrap_evt)
    );

    assign duty_rdy = !pend_vld;
    assign xfer     = duty_vld && duty_rdy;
    assign apply    = wrap_evt && pend_vld;

    // A pending value takes effect in the very wrap cycle that applies it,
    // so the first count of the new period already uses the new duty.
    assign duty_eff = apply ? pend : duty_act;

    // xfer and apply are mutually exclusive (xfer needs pend empty, apply
    // needs it full), so a value loaded on a wrap cycle waits for the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pend_vld <= 1'b0;
            duty_act <= '0;
            pwm      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            if (apply) begin
                duty_act <= pend;
                pend_vld <= 1'b0;
            end else if (xfer) begin
                pend     <= sat(duty_in);
                pend_vld <= 1'b1;
            end
            pwm  <= en && ({1'b0, cnt} < duty_eff);
            wrap <= wrap_evt;
        end
    end

    assign duty_cur = duty_act;

endmodule : pwm_from_cnt
`default_nettype wire

// File: tb/tb_pwm_from_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_from_cnt
// Purpose  : Scoreboard bench for pwm_from_cnt. The stimulus process drives
//            one counter sample per cycle, predicts the block's outputs from
//            a behavioural model and queues the prediction; a monitor pops
//            and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_from_cnt;

    localparam int W    = 4;
    localparam int FULL = 1 << W;

    typedef struct {
        logic       pwm;
        logic       wrap;
        logic [4:0] cur;
        logic       rdy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] cnt = '0;
    logic         en = 1'b0;
    logic [W:0]   duty_in = '0;
    logic         duty_vld = 1'b0;
    logic         duty_rdy;
    logic [W:0]   duty_cur;
    logic         pwm;
    logic         wrap;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    // Behavioural model state: last counter sample, waiting duty values,
    // and the duty in force.
    int m_prev   = 0;
    int m_wait[$];
    int m_active = 0;

    pwm_from_cnt #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .en       (en),
        .duty_in  (duty_in),
        .duty_vld (duty_vld),
        .duty_rdy (duty_rdy),
        .duty_cur (duty_cur),
        .pwm      (pwm),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Predict the state after the coming rising edge.
    task automatic model_step(input logic r, input int c, input logic e, input int din, input logic dv);
        exp_t x;
        int   eff;
        logic period_start;
        logic take;
        if (!r) begin
            m_prev   = 0;
            m_active = 0;
            m_wait.delete();
            x.pwm = 1'b0; x.wrap = 1'b0; x.cur = '0; x.rdy = 1'b1;
        end else begin
            period_start = (c == 0) && (m_prev != 0);
            take         = dv && (m_wait.size() == 0);
            if (period_start && m_wait.size() != 0)
                m_active = m_wait.pop_front();
            eff = m_active;
            if (take)
                m_wait.push_back((din > FULL) ? FULL : din);
            m_prev = c;
            x.pwm  = e && (c < eff);
            x.wrap = period_start;
            x.cur  = 5'(m_active);
            x.rdy  = (m_wait.size() == 0);
        end
        sb.push_back(x);
    endtask

    task automatic step(input logic r, input int c, input logic e, input int din, input logic dv);
        @(negedge clk);
        rst      = r;
        cnt      = W'(c);
        en       = e;
        duty_in  = 5'(din);
        duty_vld = dv;
        model_step(r, c, e, din, dv);
    endtask

    // One full counter period with an optional load at count ld_at.
    task automatic period(input int ld_at, input int din);
        for (int c = 0; c < FULL; c++)
            step(1'b1, c, 1'b1, din, c == ld_at);
    endtask

    // Monitor: compare after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("pwm",      pwm,      x.pwm);
                chk("wrap",     wrap,     x.wrap);
                chk("duty_cur", duty_cur, x.cur);
                chk("duty_rdy", duty_rdy, x.rdy);
            end
        end
    end

    initial begin
        int c;
        // Reset held for a few cycles.
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 0, 1'b0);

        // Duty 0: pwm stays low, wraps after each zero except the first.
        period(-1, 0);
        period(-1, 0);

        // Load 4 at count 7.
        period(7, 4);
        period(-1, 0);
        period(-1, 0);

        // Load 9 on the wrap cycle: old duty for this period, 9 at the next.
        period(0, 9);
        period(-1, 0);

        // Full scale and above-full-scale saturation.
        period(5, 16);
        period(-1, 0);
        period(5, 31);
        period(-1, 0);

        // 3 then 5 held with valid high across the wrap.
        for (int c2 = 0; c2 < FULL; c2++)
            step(1'b1, c2, 1'b1, (c2 < 3) ? 3 : 5, c2 >= 2);
        for (int c2 = 0; c2 < 3; c2++)
            step(1'b1, c2, 1'b1, 5, 1'b1);
        for (int c2 = 3; c2 < FULL; c2++)
            step(1'b1, c2, 1'b1, 0, 1'b0);
        period(-1, 0);
        period(-1, 0);

        // Randomized: jumps to zero, parked counter, random enable and loads.
        c = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0)
                c = 0;
            else if (c == 0 && $urandom_range(0, 3) == 0)
                c = 0;
            else
                c = (c + 1) % FULL;
            step(1'b1, c, $urandom_range(0, 7) != 0, $urandom_range(0, 31),
                 $urandom_range(0, 5) == 0);
        end

        // Duty 6 in force, 7 pending, then asynchronous reset mid-period.
        period(3, 6);
        period(-1, 0);
        for (int c2 = 0; c2 < 10; c2++)
            step(1'b1, c2, 1'b1, 7, c2 == 4);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_pwm",  pwm,      1'b0);
        chk("async_wrap", wrap,     1'b0);
        chk("async_cur",  duty_cur, 5'd0);
        chk("async_rdy",  duty_rdy, 1'b1);
        for (int c2 = 10; c2 < 13; c2++)
            step(1'b0, c2, 1'b1, 0, 1'b0);
        for (int c2 = 13; c2 < FULL; c2++)
            step(1'b1, c2, 1'b1, 0, 1'b0);
        period(-1, 0);
        period(-1, 0);
        // Resume with a fresh load.
        period(8, 10);
        period(-1, 0);

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pwm_from_cnt
`default_nettype wire
